// File: rtl/sync_rr_lock_ctrl_pkg.sv
// Shared definitions for the synchronous round-robin lock controller.
//   lock_state_e : controller FSM states
//   clog2        : ceiling log2 used for parameter-derived widths
//   width_of     : clog2 clamped to at least one bit, for vector widths
//   ACK_NONE     : all-low grant vector (slice to N bits at use)
package sync_rr_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } lock_state_e;

  localparam logic [15:0] ACK_NONE = '0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int width_of(input int value);
    return (value <= 2) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/sync_rr_lock_ctrl_sync_ff.sv
// Single-bit synchronizer, STAGES flops deep, asynchronously cleared.
// STAGES = 0 passes d_i straight through for same-domain requesters.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (clears all stages)
//   d_i    : asynchronous input bit
//   q_o    : synchronized output bit
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk_i | rst_i;
    assign q_o = d_i;
  end else begin : g_sync
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign q_o = sync_q[STAGES-1];
  end

endmodule

// File: rtl/sync_rr_lock_ctrl.sv
// Round-robin mutual-exclusion controller sharing one lock between N
// requesters over a 4-phase req/ack handshake, with a sticky grant-hold
// watchdog and owner reporting.
// Ports:
//   clk_i      : system clock, rising edge
//   reset_i    : asynchronous active-high reset
//   req_i      : per-requester level request
//   ack_o      : per-requester registered grant, one-hot or zero
//   owner_o    : index of the current holder, valid while busy_o
//   busy_o     : a grant is outstanding
//   hold_err_o : sticky, a grant was held MAX_HOLD cycles (MAX_HOLD > 0)
module sync_rr_lock_ctrl
  import sync_rr_lock_ctrl_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_HOLD    = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N-1:0]             req_i,
  output logic [N-1:0]             ack_o,
  output logic [width_of(N)-1:0]   owner_o,
  output logic                     busy_o,
  output logic                     hold_err_o
);

  localparam int OW = width_of(N);
  localparam int HW = width_of(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);

  lock_state_e     state_q, state_d;
  logic [N-1:0]    rq;
  logic [N-1:0]    ack_q, ack_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            busy_q, busy_d;
  logic            hold_err_q, hold_err_d;
  logic [OW-1:0]   winner;

  for (genvar g = 0; g < N; g++) begin : g_req_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (reset_i),
      .d_i   (req_i[g]),
      .q_o   (rq[g])
    );
  end

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] vec,
                                            input logic [OW-1:0] ptr);
    logic [N-1:0] rot;
    int           sel;
    rot = N'({vec, vec} >> ptr);
    sel = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sel = i;
    end
    return OW'((sel + int'(ptr)) % N);
  endfunction

  assign winner = rr_pick(rq, rr_ptr_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      ack_q      <= ACK_NONE[N-1:0];
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      hold_err_q <= hold_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|rq) state_d = ST_GRANT;
      ST_GRANT:   if (!rq[owner_q]) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d      = ack_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    hold_err_d = hold_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|rq) begin
          ack_d         = ACK_NONE[N-1:0];
          ack_d[winner] = 1'b1;
          owner_d       = winner;
          busy_d        = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      ST_GRANT: begin
        if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + HW'(1);
        // The watchdog only flags; the holder keeps the lock.
        if (MAX_HOLD != 0 && hold_cnt_d == HOLD_SAT) hold_err_d = 1'b1;
        if (!rq[owner_q]) begin
          ack_d    = ACK_NONE[N-1:0];
          busy_d   = 1'b0;
          rr_ptr_d = OW'((int'(owner_q) + 1) % N);
        end
      end
      default: ;
    endcase
  end

  assign ack_o      = ack_q;
  assign owner_o    = owner_q;
  assign busy_o     = busy_q;
  assign hold_err_o = hold_err_q;

endmodule

// File: tb/tb_sync_rr_lock_ctrl.sv
module tb_sync_rr_lock_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] req0 = 4'b0;
  logic [3:0] ack, ack0;
  logic [1:0] owner, owner0;
  logic       busy, busy0, hold_err, hold_err0;

  always #5 clk = ~clk;

  sync_rr_lock_ctrl #(.N(4), .SYNC_STAGES(2), .MAX_HOLD(8)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .ack_o(ack),
    .owner_o(owner), .busy_o(busy), .hold_err_o(hold_err)
  );

  sync_rr_lock_ctrl #(.N(4), .SYNC_STAGES(0), .MAX_HOLD(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .req_i(req0), .ack_o(ack0),
    .owner_o(owner0), .busy_o(busy0), .hold_err_o(hold_err0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] owner;
  } grant_t;

  grant_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_grant(input int idx);
    grant_t g;
    g.ack   = 4'(1 << idx);
    g.owner = 2'(idx);
    exp_q.push_back(g);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output int idx, input int budget);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if (ack != 4'b0) begin
        for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_ack: timeout after %0d cycles, ack=%b", budget, ack);
    idx = 0;
  endtask

  task automatic wait_ack_zero(input int budget);
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if (ack == 4'b0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_ack_zero: timeout after %0d cycles, ack=%b", budget, ack);
  endtask

  // Monitor: grant events are popped from the scoreboard; invariants every cycle.
  logic [3:0] prev_ack = 4'b0;
  int         low_cnt = 2;

  always @(negedge clk) begin
    grant_t g;
    n_cmp++;
    if ($countones(ack) > 1) begin
      n_bad++;
      $display("FAIL onehot: ack=%b, required at most one bit", ack);
    end
    check("busy_vs_ack", 32'(busy), 32'(ack != 4'b0));
    if (ack != 4'b0 && prev_ack == 4'b0) begin
      n_cmp++;
      if (low_cnt < 2) begin
        n_bad++;
        $display("FAIL gap: ack low for %0d cycles, required >= 2", low_cnt);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: ack=%b, no grant expected", ack);
      end else begin
        g = exp_q.pop_front();
        check("grant_ack", 32'(ack), 32'(g.ack));
        check("grant_owner", 32'(owner), 32'(g.owner));
      end
    end
    if (ack == 4'b0) low_cnt++;
    else low_cnt = 0;
    prev_ack = ack;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;

    // Reset state
    tick(3);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hold_err", 32'(hold_err), 32'h0);
    reset = 1'b0;

    // 1: single requester latency and release
    push_grant(0);
    tick(1);
    req = 4'b0001;
    tick(2);
    check("t1_not_early", 32'(ack), 32'h0);
    tick(1);
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_owner", 32'(owner), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick(2);
    check("t1_still_held", 32'(ack), 32'h1);
    tick(1);
    check("t1_released", 32'(ack), 32'h0);
    check("t1_busy_low", 32'(busy), 32'h0);

    // 2: all requesting, rotation 0,1,2,3,0
    tick(3);
    pulse_reset();
    push_grant(0); push_grant(1); push_grant(2); push_grant(3); push_grant(0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, 20);
      if (k == 4) req = 4'b0000;
      else req[idx] = 1'b0;
      wait_ack_zero(20);
      if (k < 4) req[idx] = 1'b1;
    end

    // 3: fairness with a quick re-request, then rr_ptr=3 picks 3 over 0
    tick(3);
    pulse_reset();
    push_grant(0); push_grant(2); push_grant(3); push_grant(0);
    req = 4'b0101;
    wait_ack(idx, 20);
    req = 4'b0100;
    tick(1);
    req = 4'b0101;
    wait_ack_zero(20);
    wait_ack(idx, 20);
    req = 4'b1001;
    wait_ack_zero(20);
    wait_ack(idx, 20);
    req = 4'b0001;
    wait_ack_zero(20);
    wait_ack(idx, 20);
    req = 4'b0000;
    wait_ack_zero(20);

    // 4: watchdog, 7-cycle hold is clean, 8-cycle hold trips and sticks
    tick(3);
    push_grant(1);
    req = 4'b0010;
    wait_ack(idx, 20);
    tick(4);
    req = 4'b0000;
    tick(2);
    check("t4_h7_held", 32'(ack), 32'h2);
    tick(1);
    check("t4_h7_released", 32'(ack), 32'h0);
    check("t4_h7_no_err", 32'(hold_err), 32'h0);

    push_grant(1);
    req = 4'b0010;
    wait_ack(idx, 20);
    tick(5);
    req = 4'b0000;
    tick(2);
    check("t4_h8_pre_err", 32'(hold_err), 32'h0);
    check("t4_h8_held", 32'(ack), 32'h2);
    tick(1);
    check("t4_h8_released", 32'(ack), 32'h0);
    check("t4_h8_err", 32'(hold_err), 32'h1);
    tick(4);
    check("t4_err_sticky", 32'(hold_err), 32'h1);

    // 5: async reset mid-grant, then normal re-grant
    push_grant(1);
    req = 4'b0010;
    wait_ack(idx, 20);
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_ack", 32'(ack), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_err", 32'(hold_err), 32'h0);
    push_grant(1);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("t5_not_early", 32'(ack), 32'h0);
    tick(1);
    check("t5_regrant", 32'(ack), 32'h2);
    check("t5_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    wait_ack_zero(20);

    // 6: bypassed synchronizer, one-cycle pulse grants and releases
    tick(2);
    req0 = 4'b0010;
    tick(1);
    check("t6_ack", 32'(ack0), 32'h2);
    check("t6_busy", 32'(busy0), 32'h1);
    req0 = 4'b0000;
    tick(1);
    check("t6_released", 32'(ack0), 32'h0);
    check("t6_busy_low", 32'(busy0), 32'h0);
    tick(2);
    req0 = 4'b0010;
    tick(1);
    check("t6_regrant", 32'(ack0), 32'h2);
    check("t6_owner", 32'(owner0), 32'h1);
    req0 = 4'b0000;
    tick(1);
    check("t6_rerelease", 32'(ack0), 32'h0);
    check("t6_no_err", 32'(hold_err0), 32'h0);

    tick(4);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
